// File: rtl/truth_table_sweeper_if.sv
// Control/status and function-block bus for truth_table_sweeper.
// The slave modport is the sweeper. It takes start/abort and the function
// output F, and drives A..D plus the sweep results. The master modport is
// whoever controls the sweep and hosts the function block.
interface truth_table_sweeper_if;
  logic        start;
  logic        abort;
  logic        F;
  logic        A;
  logic        B;
  logic        C;
  logic        D;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] tt;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail_idx;
  logic        first_fail_vld;

  modport slave (
    input  start, abort, F,
    output A, B, C, D, busy, done, pass, tt, mismatch_cnt,
           first_fail_idx, first_fail_vld
  );

  modport master (
    output start, abort, F,
    input  A, B, C, D, busy, done, pass, tt, mismatch_cnt,
           first_fail_idx, first_fail_vld
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks {A,B,C,D} through 0..15, holds each combination
// for SETTLE_CYCLES+1 clocks, samples F into tt[idx] on the last edge of the
// window, and counts mismatches against EXP_MASK.
// Optional feature: define FIRST_FAIL_EN to capture the index of the first
// mismatching combination of a sweep. Without it, first_fail_idx and
// first_fail_vld are tied to 0.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXP_MASK      = 16'hF444
) (
  input logic                 clk,
  input logic                 rst_n,
  truth_table_sweeper_if.slave bus
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);
  localparam logic [3:0] LAST_IDX    = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  abcd_q, abcd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] tt_q, tt_d;
  logic [4:0]  mcnt_q, mcnt_d;

  logic        sample;
  logic        miss;
  logic [4:0]  mcnt_inc;

  // The last edge of a settle window is the one that samples F.
  assign sample   = (state_q == SETTLE) && (cnt_q == SETTLE_LAST);
  assign miss     = (bus.F != EXP_MASK[idx_q]);
  // At most 16 increments per sweep, so 5 bits never wrap.
  assign mcnt_inc = mcnt_q + {4'd0, miss};

`ifdef FIRST_FAIL_EN
  logic [3:0] ff_idx_q, ff_idx_d;
  logic       ff_vld_q, ff_vld_d;
`endif

  // Next-state and next-output decode for the sweep controller.
  // NOTE: combinational logic uses blocking '=' and assigns every target a
  // default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    abcd_d  = abcd_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    tt_d    = tt_q;
    mcnt_d  = mcnt_q;
`ifdef FIRST_FAIL_EN
    ff_idx_d = ff_idx_q;
    ff_vld_d = ff_vld_q;
`endif

    if (bus.abort) begin
      // Abort wins over start and drops every partial result.
      state_d = IDLE;
      idx_d   = 4'd0;
      cnt_d   = 8'd0;
      abcd_d  = 4'd0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      tt_d    = 16'd0;
      mcnt_d  = 5'd0;
`ifdef FIRST_FAIL_EN
      ff_idx_d = 4'd0;
      ff_vld_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d = SETTLE;
            idx_d   = 4'd0;
            cnt_d   = 8'd0;
            abcd_d  = 4'd0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            tt_d    = 16'd0;
            mcnt_d  = 5'd0;
`ifdef FIRST_FAIL_EN
            ff_idx_d = 4'd0;
            ff_vld_d = 1'b0;
`endif
          end
        end

        SETTLE: begin
          // start is deliberately not decoded here: a sweep cannot be restarted.
          if (!sample) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            tt_d[idx_q] = bus.F;
            mcnt_d      = mcnt_inc;
`ifdef FIRST_FAIL_EN
            if (miss && !ff_vld_q) begin
              ff_idx_d = idx_q;
              ff_vld_d = 1'b1;
            end
`endif
            if (idx_q != LAST_IDX) begin
              idx_d  = idx_q + 4'd1;
              abcd_d = idx_q + 4'd1;
              cnt_d  = 8'd0;
            end else begin
              state_d = DONE;
              idx_d   = 4'd0;
              cnt_d   = 8'd0;
              abcd_d  = 4'd0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (mcnt_inc == 5'd0);
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State and result registers; everything clears on reset, including tt.
  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 8'd0;
      abcd_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tt_q    <= 16'd0;
      mcnt_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abcd_q  <= abcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tt_q    <= tt_d;
      mcnt_q  <= mcnt_d;
    end
  end

`ifdef FIRST_FAIL_EN
  // First-failure capture registers, cleared by reset, start and abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_idx_q <= 4'd0;
      ff_vld_q <= 1'b0;
    end else begin
      ff_idx_q <= ff_idx_d;
      ff_vld_q <= ff_vld_d;
    end
  end

  assign bus.first_fail_idx = ff_idx_q;
  assign bus.first_fail_vld = ff_vld_q;
`else
  assign bus.first_fail_idx = 4'h0;
  assign bus.first_fail_vld = 1'b0;
`endif

  assign {bus.A, bus.B, bus.C, bus.D} = abcd_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.tt           = tt_q;
  assign bus.mismatch_cnt = mcnt_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper. Instance dut uses a settle time of 2 and
// instance dut0 uses a settle time of 0. Both drive a modelled function block
// whose F follows a selectable reference: (A&B)|(C&~D), stuck-at-0, or a
// random truth table.
module tb_truth_table_sweeper;

  localparam logic [15:0] EXP = 16'hF444;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          f_mode   = 0;
  logic [15:0] rnd_tbl  = 16'h0;
  logic [3:0]  seq [0:63];

  truth_table_sweeper_if bus ();
  truth_table_sweeper_if bus0 ();

  truth_table_sweeper #(.SETTLE_CYCLES(2), .EXP_MASK(EXP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  truth_table_sweeper #(.SETTLE_CYCLES(0), .EXP_MASK(EXP)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  always #5 clk = ~clk;

  // Reference function block: F from the combination index k = {A,B,C,D}.
  function automatic logic f_model(input int mode, input logic [15:0] tbl, input logic [3:0] k);
    logic [15:0] t;
    t = tbl;
    case (mode)
      0:       return (k[3] & k[2]) | (k[1] & ~k[0]);
      1:       return 1'b0;
      default: return t[k];
    endcase
  endfunction

  function automatic logic [15:0] exp_table(input int mode, input logic [15:0] tbl);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k] = f_model(mode, tbl, 4'(k));
    return r;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    for (int k = 0; k < 16; k++) if (v[k]) return 4'(k);
    return 4'd0;
  endfunction

  always_comb begin
    bus.F  = f_model(f_mode, rnd_tbl, {bus.A, bus.B, bus.C, bus.D});
    bus0.F = f_model(f_mode, rnd_tbl, {bus0.A, bus0.B, bus0.C, bus0.D});
  end

  function automatic logic [32:0] outs();
    return {bus.busy, bus.done, bus.pass, bus.tt, bus.mismatch_cnt,
            bus.first_fail_idx, bus.first_fail_vld, bus.A, bus.B, bus.C, bus.D};
  endfunction

  function automatic logic [32:0] outs0();
    return {bus0.busy, bus0.done, bus0.pass, bus0.tt, bus0.mismatch_cnt,
            bus0.first_fail_idx, bus0.first_fail_vld, bus0.A, bus0.B, bus0.C, bus0.D};
  endfunction

  // Pulses start on dut and waits (bounded) for done; lat is edges after e0.
  task automatic run_sweep(input int restart_at, output int lat);
    int cyc;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    cyc = 0;
    seq[0] = {bus.A, bus.B, bus.C, bus.D};
    while (bus.done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == restart_at);
      if (cyc < 64) seq[cyc] = {bus.A, bus.B, bus.C, bus.D};
    end
    bus.start = 1'b0;
    lat = cyc;
  endtask

  // Compares the results of a finished sweep against the reference table.
  task automatic check_results(input string name, input logic [15:0] exp_tt);
    logic [15:0] diff;
    logic [4:0]  exp_cnt;
    logic [3:0]  exp_ffi;
    logic        exp_ffv;
    diff    = exp_tt ^ EXP;
    exp_cnt = 5'($countones(diff));
`ifdef FIRST_FAIL_EN
    exp_ffi = lowest_set(diff);
    exp_ffv = (diff != 16'd0);
`else
    exp_ffi = 4'd0;
    exp_ffv = 1'b0;
`endif
    n_checks++;
    if (bus.tt !== exp_tt) begin
      n_fail++; $display("FAIL %s tt: got %h expected %h", name, bus.tt, exp_tt);
    end
    n_checks++;
    if (bus.mismatch_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL %s mismatch_cnt: got %0d expected %0d", name, bus.mismatch_cnt, exp_cnt);
    end
    n_checks++;
    if (bus.pass !== (diff == 16'd0)) begin
      n_fail++; $display("FAIL %s pass: got %b expected %b", name, bus.pass, diff == 16'd0);
    end
    n_checks++;
    if ({bus.busy, bus.done, bus.A, bus.B, bus.C, bus.D} !== 6'b01_0000) begin
      n_fail++; $display("FAIL %s busy/done/ABCD: got %b expected 010000", name,
                         {bus.busy, bus.done, bus.A, bus.B, bus.C, bus.D});
    end
    n_checks++;
    if ({bus.first_fail_idx, bus.first_fail_vld} !== {exp_ffi, exp_ffv}) begin
      n_fail++; $display("FAIL %s first_fail idx/vld: got %0d/%b expected %0d/%b", name,
                         bus.first_fail_idx, bus.first_fail_vld, exp_ffi, exp_ffv);
    end
  endtask

  task automatic check_lat(input string name, input int lat, input int exp_lat);
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++; $display("FAIL %s done latency: got %0d expected %0d", name, lat, exp_lat);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (outs() !== 33'd0) begin
      n_fail++; $display("FAIL reset outputs: got %h expected 0", outs());
    end
    n_checks++;
    if (outs0() !== 33'd0) begin
      n_fail++; $display("FAIL reset outputs S=0: got %h expected 0", outs0());
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic_sweep();
    int lat;
    logic [32:0] held;
    f_mode = 0;
    run_sweep(-1, lat);
    check_lat("basic", lat, 48);
    check_results("basic", exp_table(0, rnd_tbl));
    held = outs();
    repeat (5) @(negedge clk);
    n_checks++;
    if (outs() !== held) begin
      n_fail++; $display("FAIL done hold: got %h expected %h", outs(), held);
    end
  endtask

  task automatic test_sequence();
    int lat;
    int bad;
    f_mode = 0;
    run_sweep(-1, lat);
    bad = 0;
    for (int j = 0; j < 48; j++) begin
      n_checks++;
      if (seq[j] !== 4'(j / 3)) begin
        n_fail++; bad++;
        if (bad <= 4) $display("FAIL sequence at cycle %0d: got %b expected %b", j, seq[j], 4'(j / 3));
      end
    end
  endtask

  task automatic test_stuck_zero();
    int lat;
    f_mode = 1;
    run_sweep(-1, lat);
    check_lat("stuck0", lat, 48);
    check_results("stuck0", 16'h0000);
    f_mode = 0;
  endtask

  task automatic test_restart_ignored();
    int lat;
    f_mode = 0;
    run_sweep(10, lat);
    check_lat("restart", lat, 48);
    check_results("restart", 16'hF444);
  endtask

  task automatic test_abort_and_reset();
    int lat;
    f_mode = 0;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (20) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (outs() !== 33'd0) begin
      n_fail++; $display("FAIL abort outputs: got %h expected 0", outs());
    end
    @(negedge clk) bus.abort = 1'b0;
    run_sweep(-1, lat);
    check_lat("after abort", lat, 48);
    check_results("after abort", 16'hF444);

    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 33'd0) begin
      n_fail++; $display("FAIL async reset outputs: got %h expected 0", outs());
    end
    @(negedge clk) rst_n = 1'b1;
    run_sweep(-1, lat);
    check_lat("after reset", lat, 48);
    check_results("after reset", 16'hF444);
  endtask

  task automatic test_random_tables();
    int lat;
    f_mode = 2;
    for (int it = 0; it < 8; it++) begin
      if (it == 0)      rnd_tbl = EXP ^ 16'h8000;
      else if (it == 1) rnd_tbl = ~EXP;
      else if (it == 2) rnd_tbl = EXP;
      else              rnd_tbl = 16'($urandom);
      run_sweep(-1, lat);
      check_lat("random", lat, 48);
      check_results("random", rnd_tbl);
    end
    f_mode = 0;
  endtask

  task automatic test_zero_settle();
    int cyc;
    logic [3:0] s0 [0:31];
    f_mode = 0;
    @(negedge clk) bus0.start = 1'b1;
    @(negedge clk) bus0.start = 1'b0;
    cyc = 0;
    s0[0] = {bus0.A, bus0.B, bus0.C, bus0.D};
    while (bus0.done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc < 32) s0[cyc] = {bus0.A, bus0.B, bus0.C, bus0.D};
    end
    check_lat("S=0", cyc, 16);
    for (int j = 0; j < 16; j++) begin
      n_checks++;
      if (s0[j] !== 4'(j)) begin
        n_fail++; $display("FAIL S=0 sequence at cycle %0d: got %b expected %b", j, s0[j], 4'(j));
      end
    end
    n_checks++;
    if ({bus0.tt, bus0.pass, bus0.busy} !== {16'hF444, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL S=0 tt/pass/busy: got %h/%b/%b expected f444/1/0",
                         bus0.tt, bus0.pass, bus0.busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_sequence();
    test_stuck_zero();
    test_restart_ignored();
    test_abort_and_reset();
    test_random_tables();
    test_zero_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
